// File: rtl/tone_synth_if.sv
// Key/octave inputs toward the tone synth and the tone/note outputs back from it.
// The tone side uses slave; the key-scanning side (or a bench) uses master.
interface tone_synth_if #(
  parameter int NUM_KEYS = 8
);
  localparam int IDX_W = $clog2(NUM_KEYS);

  logic [NUM_KEYS-1:0] sw;
  logic [1:0]          octave;
  logic                FREQ;
  logic [IDX_W-1:0]    note;
  logic                note_valid;

  modport master (output sw, output octave, input FREQ, input note, input note_valid);
  modport slave  (input sw, input octave, output FREQ, output note, output note_valid);
endinterface

// File: rtl/tone_synth.sv
// Square-wave tone from a table of per-key half periods; key-to-tone latency 3 cycles (2 sync + 1).
// No backpressure: the output runs freely and pitch changes land only on half-period boundaries.
module tone_synth #(
  parameter int                        NUM_KEYS     = 8,
  parameter int                        DIV_W        = 18,
  parameter logic [NUM_KEYS*DIV_W-1:0] HALF_PERIODS = {18'd191113, 18'd170265, 18'd151685, 18'd143172,
                                                       18'd127551, 18'd113636, 18'd101239, 18'd95557},
  parameter bit                        MSB_PRIORITY = 1'b1,
  parameter int unsigned               RELEASE_CYC  = 5000000
) (
  input logic         CLK,
  input logic         RESET,
  tone_synth_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam int REL_W = (RELEASE_CYC > 0) ? $clog2(RELEASE_CYC + 1) : 1;
  localparam logic [REL_W-1:0] REL_INIT = REL_W'(RELEASE_CYC);

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

  logic [NUM_KEYS-1:0] sw_s1, sw_s2;
  logic [1:0]          oct_s1, oct_s2;
  state_t              state, state_n;
  logic                freq, freq_n;
  logic [DIV_W-1:0]    cnt, cnt_n, h_cur, h_cur_n;
  logic [IDX_W-1:0]    note, note_n;
  logic [REL_W-1:0]    rel_cnt, rel_n;

  logic                sel_valid;
  logic [IDX_W-1:0]    sel_idx;
  logic [DIV_W-1:0]    h_base, h_sh, h_new;
  logic                boundary;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      oct_s1  <= '0;
      oct_s2  <= '0;
      state   <= IDLE;
      freq    <= 1'b0;
      cnt     <= '0;
      h_cur   <= '0;
      note    <= '0;
      rel_cnt <= '0;
    end else begin
      sw_s1   <= bus.sw;
      sw_s2   <= sw_s1;
      oct_s1  <= bus.octave;
      oct_s2  <= oct_s1;
      state   <= state_n;
      freq    <= freq_n;
      cnt     <= cnt_n;
      h_cur   <= h_cur_n;
      note    <= note_n;
      rel_cnt <= rel_n;
    end
  end

  // Last match in scan order wins, so the scan direction sets the priority.
  always_comb begin
    sel_idx = '0;
    if (MSB_PRIORITY) begin
      for (int k = 0; k < NUM_KEYS; k++)
        if (sw_s2[k]) sel_idx = IDX_W'(k);
    end else begin
      for (int k = NUM_KEYS - 1; k >= 0; k--)
        if (sw_s2[k]) sel_idx = IDX_W'(k);
    end
  end

  assign sel_valid = |sw_s2;

  always_comb begin
    h_base = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (sel_idx == IDX_W'(k)) h_base = HALF_PERIODS[k*DIV_W +: DIV_W];
    case (oct_s2)
      2'd1:    h_sh = h_base >> 1;
      2'd2:    h_sh = h_base >> 2;
      2'd3:    h_sh = h_base[DIV_W-1] ? '1 : {h_base[DIV_W-2:0], 1'b0};
      default: h_sh = h_base;
    endcase
    h_new = (h_sh < DIV_W'(2)) ? DIV_W'(2) : h_sh;
  end

  assign boundary = (cnt == '0);

  always_comb begin
    state_n = state;
    freq_n  = freq;
    cnt_n   = cnt;
    h_cur_n = h_cur;
    note_n  = note;
    rel_n   = rel_cnt;
    case (state)
      IDLE: begin
        freq_n = 1'b0;
        if (sel_valid) begin
          state_n = PLAY;
          freq_n  = 1'b1;
          cnt_n   = h_new - DIV_W'(1);
          h_cur_n = h_new;
          note_n  = sel_idx;
        end
      end
      default: begin
        // PLAY and RELEASE share the tone generator; a new pitch is only taken at a boundary.
        if (boundary) begin
          freq_n = ~freq;
          if (sel_valid) begin
            h_cur_n = h_new;
            note_n  = sel_idx;
            cnt_n   = h_new - DIV_W'(1);
          end else begin
            cnt_n   = h_cur - DIV_W'(1);
          end
        end else begin
          cnt_n = cnt - DIV_W'(1);
        end
        if (state == PLAY) begin
          if (!sel_valid) begin
            state_n = RELEASE;
            rel_n   = REL_INIT;
          end
        end else begin
          if (rel_cnt != '0) rel_n = rel_cnt - REL_W'(1);
          if (sel_valid) begin
            state_n = PLAY;
          end else if (rel_cnt == '0 && boundary && freq) begin
            state_n = IDLE;
            freq_n  = 1'b0;
          end
        end
      end
    endcase
  end

  assign bus.FREQ       = freq;
  assign bus.note       = note;
  assign bus.note_valid = (state != IDLE);
endmodule
